// File: rtl/hstl_rx_sampler.sv
// Serial frame receiver for a shared tri-state HSTL line: synchronizes the pad input,
// waits out bus turnaround after the local driver releases, and recovers start/stop framed words.
module hstl_rx_sampler #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV    = 16,
   parameter int unsigned TURN   = 4
) (
   input  logic              C,
   input  logic              R,
   input  logic              I,
   input  logic              T,
   output logic [DATA_W-1:0] DATA,
   output logic              VALID,
   output logic              FERR,
   output logic              BUSY,
   output logic              Q
);

   localparam int unsigned CW = $clog2(DIV);
   localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned GW = (TURN > 0) ? $clog2(TURN + 1) : 1;

   localparam logic [CW-1:0] CNT_HALF   = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL   = CW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
   localparam logic [GW-1:0] GUARD_INIT = GW'(TURN);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               s1;
   logic               s2;
   logic [GW-1:0]      guard;
   logic               armed;
   logic               abort;
   logic [CW-1:0]      cnt;
   logic [BW-1:0]      bitn;
   logic [DATA_W-1:0]  sr;

   always_ff @(posedge C) begin
      if (R) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= I;
         s2 <= s1;
      end
   end

   // Guard holds off arming for TURN cycles after the local driver lets go of the line.
   always_ff @(posedge C) begin
      if (R || !T)
         guard <= GUARD_INIT;
      else if (guard != '0)
         guard <= guard - 1'b1;
   end

   assign armed = T && (guard == '0);
   assign abort = !T && (state != ST_IDLE);

   always_ff @(posedge C) begin
      if (R)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (armed && !s2) state_nxt = ST_START;
         ST_START: if (cnt == CNT_HALF) state_nxt = s2 ? ST_IDLE : ST_DATA;
         ST_DATA:  if (cnt == CNT_FULL && bitn == BIT_LAST) state_nxt = ST_STOP;
         ST_STOP:  if (cnt == CNT_FULL) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort)
         state_nxt = ST_IDLE;
   end

   always_comb begin
      BUSY = (state != ST_IDLE);
      Q    = s2;
   end

   // Abort takes priority over the stop-bit sample so an aborted frame never pulses.
   always_ff @(posedge C) begin
      if (R) begin
         cnt   <= '0;
         bitn  <= '0;
         sr    <= '0;
         DATA  <= '0;
         VALID <= 1'b0;
         FERR  <= 1'b0;
      end else begin
         VALID <= 1'b0;
         FERR  <= 1'b0;
         if (abort) begin
            cnt  <= '0;
            bitn <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  cnt  <= '0;
                  bitn <= '0;
               end
               ST_START: cnt <= (cnt == CNT_HALF) ? '0 : cnt + 1'b1;
               ST_DATA: begin
                  if (cnt == CNT_FULL) begin
                     cnt      <= '0;
                     sr[bitn] <= s2;
                     bitn     <= bitn + 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_STOP: begin
                  if (cnt == CNT_FULL) begin
                     cnt <= '0;
                     if (s2) begin
                        DATA  <= sr;
                        VALID <= 1'b1;
                     end else begin
                        FERR <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: cnt <= '0;
            endcase
         end
      end
   end

endmodule
